// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state type and small op-decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between a requester and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, hi, lo, div_zero
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; with neg tied to the sign bit it
// yields the magnitude of a signed operand.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = neg ? (~val + WIDTH'(1)) : val;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) unit sharing
// one 2*WIDTH+1-bit working register.
//
// state | meaning
// IDLE  | waiting for start, results held
// PREP  | take magnitudes, record result signs, clear counter
// CALC  | one radix-2 step per cycle, WIDTH cycles
// FIX   | sign-correct and load hi/lo
// DONE  | one-cycle done pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int AW = 2 * WIDTH + 1;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             sgn;
  logic             is_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff, rem_nxt;
  logic             q_bit;

  assign sgn    = op_is_signed(op_q);
  assign is_div = op_is_div(op_q);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .val(a_q), .neg(sgn & a_q[WIDTH-1]), .res(mag_a)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .val(b_q), .neg(sgn & b_q[WIDTH-1]), .res(mag_b)
  );
  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .val(acc_q[2*WIDTH-1:0]), .neg(neg_lo_q), .res(prod_fix)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .val(acc_q[WIDTH-1:0]), .neg(neg_lo_q), .res(quo_fix)
  );
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .res(rem_fix)
  );

  // Multiply keeps the partial product in the upper half and shifts the
  // multiplier out of the bottom; divide shifts the dividend into the
  // remainder and builds the quotient from the bottom.
  always_comb begin
    mul_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    q_bit    = ~rem_diff[WIDTH];
    rem_nxt  = q_bit ? rem_diff : rem_sh;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        neg_lo_d = sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_hi_d = sgn & a_q[WIDTH-1];
        cnt_d    = '0;
        acc_d    = {{(WIDTH+1){1'b0}}, mag_a};
        b_d      = mag_b;
        if (is_div && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = is_div ? {rem_nxt, acc_q[WIDTH-2:0], q_bit}
                       : {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Zero-divisor entry arrives with done low: spend one cycle raising it.
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32), timing counted in rising
// edges after the edge that samples start.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hl, input logic exp_dz,
                        input int exp_edge, input int intr_edge, input bit rel);
    int got_edge;
    bit busy_bad;
    got_edge = -1;
    busy_bad = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    if (rel) reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (!bus.busy) busy_bad = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        got_edge = k;
        break;
      end
      if (!bus.busy) busy_bad = 1'b1;
      if (k == intr_edge) begin
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = 32'h0000_FFFF;
        bus.src_b = 32'h0000_0001;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_edge"}, 64'(got_edge), 64'(exp_edge));
    check({tag, "_hilo"}, {bus.hi, bus.lo}, exp_hl);
    check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    check({tag, "_busy_until_done"}, 64'(busy_bad), 64'd0);
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int n_done;
    n_chk     = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    #1;
    check("reset_outputs", {29'd0, bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo}, 64'd0);
    repeat (3) @(posedge clk);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005,
           64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 34, 0, 1'b1);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, 1'b0, 34, 0, 1'b0);
    run_op("multu_carry", OP_MULTU, 32'h0001_0000, 32'h0001_0000,
           64'h0000_0001_0000_0000, 1'b0, 34, 0, 1'b0);
    run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000, 1'b0, 34, 0, 1'b0);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34, 0, 1'b0);
    run_op("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, 1'b0, 34, 0, 1'b0);
    run_op("div_pos_neg", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE,
           64'h0000_0001_FFFF_FFFD, 1'b0, 34, 0, 1'b0);
    run_op("divu_small", OP_DIVU, 32'h0000_0064, 32'h0000_0007,
           64'h0000_0002_0000_000E, 1'b0, 34, 0, 1'b0);
    run_op("divu_5_7", OP_DIVU, 32'h0000_002F, 32'h0000_0006,
           64'h0000_0005_0000_0007, 1'b0, 34, 0, 1'b0);
    run_op("divu_zero", OP_DIVU, 32'h0000_0064, 32'h0000_0000,
           64'h0000_0005_0000_0007, 1'b1, 2, 0, 1'b0);
    run_op("mult_after_dz", OP_MULT, 32'h0000_0007, 32'hFFFF_FFFA,
           64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 34, 0, 1'b0);
    run_op("start_while_busy", OP_MULTU, 32'h0000_0003, 32'h0000_0004,
           64'h0000_0000_0000_000C, 1'b0, 34, 5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("no_restart_busy", 64'(bus.busy), 64'd0);

    // Abort mid-calculation; outputs must clear without waiting for a clock.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'h1234_5678;
    bus.src_b = 32'h0000_0010;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    check("async_reset_outputs",
          {29'd0, bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    run_op("after_abort", OP_DIV, 32'hFFFF_FF9C, 32'h0000_0007,
           64'hFFFF_FFFE_FFFF_FFF2, 1'b0, 34, 0, 1'b0);

    // Start presented together with reset release.
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    run_op("first_after_release", OP_MULTU, 32'h0000_0009, 32'h0000_000B,
           64'h0000_0000_0000_0063, 1'b0, 34, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width and HI/LO width (legal range 8..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 resets the unit immediately, independent of clk.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start.
REQ-007 src_a  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-008 src_b  input  WIDTH  multiplier or divisor; sampled with start.
REQ-009 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 hi  output  WIDTH  product upper half, or remainder.
REQ-012 lo  output  WIDTH  product lower half, or quotient.
REQ-013 div_zero  output  1  set when a DIV/DIVU had divisor 0; held until the next accepted start.

Function
REQ-014 FSM states: IDLE, PREP, CALC, FIX, DONE.
REQ-015 IDLE with start=1: latch op and operands, clear div_zero, go to PREP; IDLE with start=0: stay.
REQ-016 PREP: form operand magnitudes (signed ops only), record result signs, clear the counter, go to CALC.
REQ-017 PREP, DIV/DIVU with src_b=0: set div_zero, skip CALC and FIX, go to DONE, leave hi/lo unchanged.
REQ-018 CALC: one radix-2 iteration per cycle for exactly WIDTH cycles, then go to FIX.
REQ-019 Multiply uses shift-add; divide uses restoring shift-subtract.
REQ-020 FIX: apply two's-complement sign correction, load hi/lo, go to DONE.
REQ-021 DONE: done=1 for one cycle, busy=0, return to IDLE.
REQ-022 Latency: done is high in the cycle after the (WIDTH+2)th rising edge following the start-sampling edge (edge 34 for WIDTH=32).
REQ-023 Divide-by-zero latency: done is high after the 2nd rising edge following the start-sampling edge.
REQ-024 Multiply result: {hi,lo} SHALL equal the exact 2*WIDTH-bit product, signed or unsigned per op.
REQ-025 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-026 Signed divide, most-negative value / -1: lo = most-negative value (wrap), hi = 0, no flag.
REQ-027 start while busy SHALL be ignored; operands and op SHALL NOT be re-sampled.
REQ-028 hi/lo SHALL hold their last result between operations and change only in FIX.
REQ-029 done and start SHALL NOT be accepted in the same cycle; a start in the DONE cycle is ignored.

Reset
REQ-030 On reset=0 SHALL enter IDLE with busy=0, done=0, div_zero=0, hi=0, lo=0 and counter=0, asynchronously.
REQ-031 Reset during PREP/CALC/FIX SHALL abort the operation; no done pulse is produced for it.
REQ-032 The first start after reset release SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-033 Shared package muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state typedef.
REQ-034 One sub-module, muldiv_sign_fix, SHALL be used: combinational, parametrised by WIDTH, providing magnitude and conditional negate for PREP and FIX.
REQ-035 Datapath SHALL use one 2*WIDTH+1-bit working register shared by multiply and divide; no vendor multipliers.

Verification
REQ-036 MULT, WIDTH=32, src_a=FFFFFFFD, src_b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1, done at edge 34.
REQ-037 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for edges 1..33.
REQ-038 DIV FFFFFFF9 / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.
REQ-039 DIVU 00000064 / 0 after a previous result of hi=5, lo=7 -> div_zero=1, done at edge 2, hi=5, lo=7 retained.
REQ-040 Robustness: a second start at CALC cycle 5 is ignored and the first result is correct; reset=0 at CALC cycle 10 gives all outputs 0 immediately and no done pulse; a new op after reset release completes normally.
